// File: rtl/trap_controller.sv
// Machine-mode trap controller: takes exceptions, interrupts and MRET, maintains
// the trap CSRs and raises a held redirect request towards fetch.
module trap_controller #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_exception_taken,
  input  logic [31:0] i_exception_cause,
  input  logic [31:0] i_exception_val,
  input  logic [31:0] i_exception_pc,
  input  logic        i_instr_boundary,
  input  logic        i_mret,
  input  logic        i_irq_software,
  input  logic        i_irq_timer,
  input  logic        i_irq_external,
  input  logic        i_csr_we,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  output logic [31:0] o_csr_rdata,
  output logic        o_trap_req,
  output logic [31:0] o_trap_pc,
  input  logic        i_trap_ack,
  output logic        o_flush,
  output logic        o_busy
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [2:0]  r_mie;          // {external, timer, software}
  logic [31:0] r_mtvec;
  logic [29:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_trap_pc;
  logic        r_flush;

  logic [31:0] w_mip;
  logic [31:0] w_mie;
  logic [31:0] w_mstatus;
  logic [31:0] w_pending;
  logic        w_idle;
  logic        w_irq_pending;
  logic        w_take_exc;
  logic        w_take_irq;
  logic        w_take_mret;
  logic        w_trap_entry;
  logic        w_take_any;
  logic        w_csr_wr;
  logic [3:0]  w_irq_code;
  logic [31:0] w_trap_base;
  logic [31:0] w_trap_pc_next;

  assign w_mip     = {20'b0, i_irq_external, 3'b0, i_irq_timer, 3'b0, i_irq_software, 3'b0};
  assign w_mie     = {20'b0, r_mie[2], 3'b0, r_mie[1], 3'b0, r_mie[0], 3'b0};
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign w_pending = w_mip & w_mie;

  assign w_idle        = (r_state == IDLE);
  assign w_irq_pending = r_mstatus_mie && (w_pending != 32'b0);
  assign w_take_exc    = w_idle && i_exception_taken;
  assign w_take_irq    = w_idle && !i_exception_taken && w_irq_pending && i_instr_boundary;
  assign w_take_mret   = w_idle && !i_exception_taken && !w_take_irq && i_mret;
  assign w_trap_entry  = w_take_exc || w_take_irq;
  assign w_take_any    = w_trap_entry || w_take_mret;
  assign w_csr_wr      = w_idle && i_csr_we;

  // Fixed interrupt priority: external > software > timer.
  always_comb begin
    w_irq_code = 4'd7;
    if (w_pending[11]) begin
      w_irq_code = 4'd11;
    end else if (w_pending[3]) begin
      w_irq_code = 4'd3;
    end
  end

  assign w_trap_base = {r_mtvec[31:2], 2'b00};

  always_comb begin
    w_trap_pc_next = w_trap_base;
    if (w_take_mret) begin
      w_trap_pc_next = {r_mepc, 2'b00};
    end else if (w_take_irq && (r_mtvec[1:0] == 2'b01)) begin
      w_trap_pc_next = w_trap_base + {26'b0, w_irq_code, 2'b00};
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_take_any) w_state_next = REDIRECT;
      REDIRECT: if (i_trap_ack) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // CSR writes are applied first; trap/MRET updates below override the fields they own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 3'b0;
      r_mtvec        <= RESET_MTVEC;
      r_mepc         <= 30'b0;
      r_mcause       <= 32'b0;
      r_mtval        <= 32'b0;
      r_trap_pc      <= 32'b0;
      r_flush        <= 1'b0;
    end else begin
      r_flush <= w_take_any;
      if (w_take_any) begin
        r_trap_pc <= w_trap_pc_next;
      end
      if (w_csr_wr) begin
        case (i_csr_addr)
          ADDR_MSTATUS: begin
            r_mstatus_mie  <= i_csr_wdata[3];
            r_mstatus_mpie <= i_csr_wdata[7];
          end
          ADDR_MIE:    r_mie    <= {i_csr_wdata[11], i_csr_wdata[7], i_csr_wdata[3]};
          ADDR_MTVEC:  r_mtvec  <= i_csr_wdata;
          ADDR_MEPC:   r_mepc   <= i_csr_wdata[31:2];
          ADDR_MCAUSE: r_mcause <= i_csr_wdata;
          ADDR_MTVAL:  r_mtval  <= i_csr_wdata;
          default:     ;
        endcase
      end
      if (w_trap_entry) begin
        r_mepc         <= i_exception_pc[31:2];
        r_mcause       <= w_take_exc ? i_exception_cause : {1'b1, 27'b0, w_irq_code};
        r_mtval        <= w_take_exc ? i_exception_val : 32'b0;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_take_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    o_csr_rdata = 32'b0;
    case (i_csr_addr)
      ADDR_MSTATUS: o_csr_rdata = w_mstatus;
      ADDR_MIE:     o_csr_rdata = w_mie;
      ADDR_MTVEC:   o_csr_rdata = r_mtvec;
      ADDR_MEPC:    o_csr_rdata = {r_mepc, 2'b00};
      ADDR_MCAUSE:  o_csr_rdata = r_mcause;
      ADDR_MTVAL:   o_csr_rdata = r_mtval;
      ADDR_MIP:     o_csr_rdata = w_mip;
      default:      o_csr_rdata = 32'b0;
    endcase
  end

  assign o_trap_req = (r_state == REDIRECT);
  assign o_busy     = (r_state == REDIRECT);
  assign o_trap_pc  = r_trap_pc;
  assign o_flush    = r_flush;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: exceptions, vectored interrupts, priority,
// redirect hold, MRET and asynchronous reset, with hand-computed expectations.
module tb_trap_controller;

  logic        clk;
  logic        rst_n;
  logic        exception_taken;
  logic [31:0] exception_cause;
  logic [31:0] exception_val;
  logic [31:0] exception_pc;
  logic        instr_boundary;
  logic        mret;
  logic        irq_software;
  logic        irq_timer;
  logic        irq_external;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic        trap_ack;
  logic        flush;
  logic        busy;

  int errors = 0;
  int checks = 0;

  trap_controller #(.RESET_MTVEC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_exception_taken (exception_taken),
    .i_exception_cause (exception_cause),
    .i_exception_val   (exception_val),
    .i_exception_pc    (exception_pc),
    .i_instr_boundary  (instr_boundary),
    .i_mret            (mret),
    .i_irq_software    (irq_software),
    .i_irq_timer       (irq_timer),
    .i_irq_external    (irq_external),
    .i_csr_we          (csr_we),
    .i_csr_addr        (csr_addr),
    .i_csr_wdata       (csr_wdata),
    .o_csr_rdata       (csr_rdata),
    .o_trap_req        (trap_req),
    .o_trap_pc         (trap_pc),
    .i_trap_ack        (trap_ack),
    .o_flush           (flush),
    .o_busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic ack_redirect();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    check("ack_req_drop", {31'b0, trap_req}, 32'd0);
    check("ack_busy_drop", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    exception_taken = 1'b0; exception_cause = '0; exception_val = '0; exception_pc = '0;
    instr_boundary = 1'b0; mret = 1'b0;
    irq_software = 1'b0; irq_timer = 1'b0; irq_external = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0; trap_ack = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_trap_req", {31'b0, trap_req}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_trap_pc", trap_pc, 32'd0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mtvec", 12'h305, 32'h0);
    rst_n = 1'b1;
    tick();

    // Exception in direct mode
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h300, 32'h0000_0008);
    rd("mstatus_mie_set", 12'h300, 32'h0000_1808);
    exception_taken = 1'b1; exception_cause = 32'd2;
    exception_val = 32'hDEAD_BEEF; exception_pc = 32'h40;
    tick();
    exception_taken = 1'b0;
    check("exc_trap_req", {31'b0, trap_req}, 32'd1);
    check("exc_flush", {31'b0, flush}, 32'd1);
    check("exc_busy", {31'b0, busy}, 32'd1);
    check("exc_trap_pc", trap_pc, 32'h100);
    rd("exc_mepc", 12'h341, 32'h40);
    rd("exc_mcause", 12'h342, 32'd2);
    rd("exc_mtval", 12'h343, 32'hDEAD_BEEF);
    rd("exc_mstatus", 12'h300, 32'h0000_1880);

    // Redirect held for 5 cycles without ack; mtvec write is ignored
    csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_0999;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_trap_req", {31'b0, trap_req}, 32'd1);
      check("hold_trap_pc", trap_pc, 32'h100);
      check("hold_flush", {31'b0, flush}, 32'd0);
    end
    csr_we = 1'b0;
    rd("hold_mtvec", 12'h305, 32'h100);
    ack_redirect();

    // MRET after mepc write with misaligned data
    csr_write(12'h341, 32'h0000_0083);
    rd("mepc_align", 12'h341, 32'h80);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_trap_req", {31'b0, trap_req}, 32'd1);
    check("mret_flush", {31'b0, flush}, 32'd1);
    check("mret_trap_pc", trap_pc, 32'h80);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    ack_redirect();

    // Vectored interrupt, external beats timer
    csr_write(12'h305, 32'h0000_0201);
    csr_write(12'h304, 32'h0000_0880);
    rd("mie_read", 12'h304, 32'h880);
    irq_timer = 1'b1; irq_external = 1'b1; exception_pc = 32'h124;
    tick();
    check("no_boundary_req", {31'b0, trap_req}, 32'd0);
    rd("mip_read", 12'h344, 32'h880);
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    check("irq_trap_req", {31'b0, trap_req}, 32'd1);
    check("irq_trap_pc", trap_pc, 32'h22C);
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    rd("irq_mtval", 12'h343, 32'h0);
    rd("irq_mepc", 12'h341, 32'h124);
    rd("irq_mstatus", 12'h300, 32'h0000_1880);
    ack_redirect();

    // Exception + pending interrupt + MRET in one cycle; mtval write loses
    csr_write(12'h300, 32'h0000_0008);
    exception_taken = 1'b1; exception_cause = 32'd5; exception_val = 32'h11;
    exception_pc = 32'h300; instr_boundary = 1'b1; mret = 1'b1;
    csr_we = 1'b1; csr_addr = 12'h343; csr_wdata = 32'h55;
    tick();
    exception_taken = 1'b0; mret = 1'b0; csr_we = 1'b0;
    check("prio_trap_req", {31'b0, trap_req}, 32'd1);
    check("prio_trap_pc", trap_pc, 32'h200);
    rd("prio_mcause", 12'h342, 32'd5);
    rd("prio_mtval", 12'h343, 32'h11);
    rd("prio_mstatus", 12'h300, 32'h0000_1880);
    ack_redirect();
    csr_write(12'h300, 32'h0000_0008);
    check("irq_after_write_req", {31'b0, trap_req}, 32'd0);
    tick();
    check("late_irq_trap_req", {31'b0, trap_req}, 32'd1);
    check("late_irq_trap_pc", trap_pc, 32'h22C);
    rd("late_irq_mcause", 12'h342, 32'h8000_000B);
    instr_boundary = 1'b0;

    // Asynchronous reset while redirecting
    #2;
    rst_n = 1'b0;
    #1;
    check("async_trap_req", {31'b0, trap_req}, 32'd0);
    check("async_busy", {31'b0, busy}, 32'd0);
    check("async_trap_pc", trap_pc, 32'h0);
    irq_timer = 1'b0; irq_external = 1'b0;
    rd("async_mstatus", 12'h300, 32'h0000_1800);
    rd("async_mie", 12'h304, 32'h0);
    rd("async_mtvec", 12'h305, 32'h0);
    rd("async_mepc", 12'h341, 32'h0);
    rd("async_mcause", 12'h342, 32'h0);
    rd("async_mtval", 12'h343, 32'h0);
    rd("async_unmapped", 12'h7C0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
